mac_accum_plane_scheduler: RTL and testbench

//  Sequences the configurable vector accumulator (mac_accumulator_config) for bit-serial MACs.
//  - Accepts one job config, then streams one partial-sum vector per bit-plane into the datapath.
//  - Holds the datapath select for the whole job.
//  - Shift-adds the per-plane reduction results, MSB plane first, into one signed result.
//  - Returns the result on a valid/ready port. Sits between the PE-array plane buffers and the output writeback.

---
 rtl/mac_accum_pkg.sv | 20 ++
 rtl/mac_plane_shift_add.sv | 42 ++++
 rtl/mac_accum_plane_scheduler.sv | 136 +++++++++++++
 tb/tb_mac_accum_plane_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_accum_pkg.sv
// Shared types and helpers for the bit-plane MAC accumulation scheduler.
package mac_accum_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } sched_state_t;

  localparam int SEL_W = 3;

  function automatic int clamp_planes(
    input int planes,
    input int max_planes
  );
    return (planes > max_planes) ? max_planes : planes;
  endfunction

endpackage

// File: rtl/mac_plane_shift_add.sv
// MSB-first shift-add of per-plane reduction results into one signed sum.
module mac_plane_shift_add
  import mac_accum_pkg::*;
#(
  parameter int RES_W     = 27,
  parameter int OUT_WIDTH = 35
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_clr,
  input  logic                        i_en,
  input  logic                        i_msb_neg,
  input  logic signed [RES_W-1:0]     i_term,
  output logic signed [OUT_WIDTH-1:0] o_acc_next
);

  logic signed [OUT_WIDTH-1:0] r_acc;
  logic                        r_first;
  logic signed [OUT_WIDTH-1:0] w_ext;
  logic signed [OUT_WIDTH-1:0] w_term;

  assign w_ext = {{(OUT_WIDTH-RES_W){i_term[RES_W-1]}}, i_term};

  // Only the first plane of a job carries the two's-complement sign weight.
  assign w_term = (r_first && i_msb_neg) ? -w_ext : w_ext;

  assign o_acc_next = (r_acc <<< 1) + w_term;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc   <= '0;
      r_first <= 1'b0;
    end else if (i_clr) begin
      r_acc   <= '0;
      r_first <= 1'b1;
    end else if (i_en) begin
      r_acc   <= o_acc_next;
      r_first <= 1'b0;
    end
  end

endmodule

// File: rtl/mac_accum_plane_scheduler.sv
// Streams bit-plane vectors into the accumulator datapath and
// shift-adds the plane results into one signed job result.
module mac_accum_plane_scheduler
  import mac_accum_pkg::*;
#(
  parameter  int DATA_WIDTH = 25,
  parameter  int VEC_LENGTH = 4,
  parameter  int MAX_PLANES = 8,
  localparam int PLANE_W    = $clog2(MAX_PLANES+1),
  localparam int RES_W      = DATA_WIDTH + 2,
  localparam int OUT_WIDTH  = RES_W + MAX_PLANES
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic                                          cfg_valid,
  output logic                                          cfg_ready,
  input  logic [SEL_W-1:0]                              cfg_sel,
  input  logic [PLANE_W-1:0]                            cfg_planes,
  input  logic                                          cfg_msb_neg,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic signed [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  in_vec,
  output logic                                          acc_en,
  output logic [SEL_W-1:0]                              acc_sel,
  output logic signed [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  acc_vec,
  input  logic signed [RES_W-1:0]                       acc_result,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic signed [OUT_WIDTH-1:0]                   out_data,
  output logic                                          busy
);

  sched_state_t r_state;
  sched_state_t w_state_nxt;

  logic [SEL_W-1:0]   r_sel;
  logic               r_msb_neg;
  logic [PLANE_W-1:0] r_planes;
  logic [PLANE_W-1:0] r_issued;
  logic [PLANE_W-1:0] w_planes_eff;
  logic               r_acc_en;
  logic               w_cfg_acc;
  logic               w_in_acc;

  logic signed [VEC_LENGTH-1:0][DATA_WIDTH-1:0] r_acc_vec;
  logic signed [OUT_WIDTH-1:0] r_out_data;
  logic signed [OUT_WIDTH-1:0] w_acc_next;

  assign w_planes_eff =
    PLANE_W'(clamp_planes(int'(cfg_planes), MAX_PLANES));

  always_comb begin
    w_state_nxt = r_state;
    cfg_ready   = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (r_state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid)
          w_state_nxt = (w_planes_eff == '0) ? DONE : RUN;
      end
      RUN: begin
        in_ready = (r_issued < r_planes);
        if (in_valid && in_ready &&
            (r_issued + PLANE_W'(1) == r_planes))
          w_state_nxt = DRAIN;
      end
      DRAIN: w_state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          cfg_ready = 1'b1;
          if (cfg_valid)
            w_state_nxt = (w_planes_eff == '0) ? DONE : RUN;
          else
            w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_cfg_acc = cfg_valid && cfg_ready;
    w_in_acc  = in_valid && in_ready;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_sel      <= '0;
      r_msb_neg  <= 1'b0;
      r_planes   <= '0;
      r_issued   <= '0;
      r_acc_en   <= 1'b0;
      r_acc_vec  <= '0;
      r_out_data <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc_en <= w_in_acc;
      if (w_in_acc) begin
        r_acc_vec <= in_vec;
        r_issued  <= r_issued + PLANE_W'(1);
      end
      if (w_cfg_acc) begin
        r_sel     <= cfg_sel;
        r_msb_neg <= cfg_msb_neg;
        r_planes  <= w_planes_eff;
        r_issued  <= '0;
      end
      // DRAIN is the last acc_en cycle, so the next sum is final.
      if (r_state == DRAIN)
        r_out_data <= w_acc_next;
      else if (w_cfg_acc && (w_planes_eff == '0))
        r_out_data <= '0;
    end
  end

  mac_plane_shift_add #(
    .RES_W     (RES_W),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_shift_add (
    .i_clk      (clk),
    .i_rst_n    (reset_n),
    .i_clr      (w_cfg_acc),
    .i_en       (r_acc_en),
    .i_msb_neg  (r_msb_neg),
    .i_term     (acc_result),
    .o_acc_next (w_acc_next)
  );

  assign acc_en   = r_acc_en;
  assign acc_sel  = r_sel;
  assign acc_vec  = r_acc_vec;
  assign out_data = r_out_data;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_mac_accum_plane_scheduler.sv
// Directed bench: lane-sum datapath stub, hand-computed job results.
module tb_mac_accum_plane_scheduler;

  localparam int DW = 25;
  localparam int VL = 4;
  localparam int MP = 8;
  localparam int PW = 4;
  localparam int RW = DW + 2;
  localparam int OW = RW + MP;

  logic                          clk = 1'b0;
  logic                          reset_n;
  logic                          cfg_valid;
  logic                          cfg_ready;
  logic [2:0]                    cfg_sel;
  logic [PW-1:0]                 cfg_planes;
  logic                          cfg_msb_neg;
  logic                          in_valid;
  logic                          in_ready;
  logic signed [VL-1:0][DW-1:0]  in_vec;
  logic                          acc_en;
  logic [2:0]                    acc_sel;
  logic signed [VL-1:0][DW-1:0]  acc_vec;
  logic signed [RW-1:0]          acc_result;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [OW-1:0]          out_data;
  logic                          busy;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int e0;
  int lane_sum;

  mac_accum_plane_scheduler #(
    .DATA_WIDTH (DW),
    .VEC_LENGTH (VL),
    .MAX_PLANES (MP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_sel     (cfg_sel),
    .cfg_planes  (cfg_planes),
    .cfg_msb_neg (cfg_msb_neg),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_vec      (in_vec),
    .acc_en      (acc_en),
    .acc_sel     (acc_sel),
    .acc_vec     (acc_vec),
    .acc_result  (acc_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Datapath stub: sum of the signed lanes, select ignored.
  always_comb begin
    lane_sum = 0;
    for (int i = 0; i < VL; i++)
      lane_sum = lane_sum + int'($signed(acc_vec[i]));
    acc_result = RW'(lane_sum);
  end

  always @(negedge clk)
    if (acc_en) en_cnt <= en_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_vec(input int a, input int b,
                         input int c, input int d);
    in_vec[0] = DW'(a);
    in_vec[1] = DW'(b);
    in_vec[2] = DW'(c);
    in_vec[3] = DW'(d);
  endtask

  task automatic start_job(input int sel, input int planes,
                           input bit msb);
    cfg_sel     = 3'(sel);
    cfg_planes  = PW'(planes);
    cfg_msb_neg = msb;
    cfg_valid   = 1'b1;
    tick();
    cfg_valid   = 1'b0;
  endtask

  // Plane sum s is split across two lanes as (s+3) + (-3).
  task automatic play(input int n, input int s[8], input int bub);
    for (int i = 0; i < n; i++) begin
      set_vec(s[i] + 3, -3, 0, 0);
      in_valid = 1'b1;
      tick();
      chk("acc_en_accept", acc_en, 1);
      in_valid = 1'b0;
      if (i < n - 1)
        for (int b = 0; b < bub; b++) begin
          tick();
          chk("acc_en_bubble", acc_en, 0);
        end
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n     = 1'b0;
    cfg_valid   = 1'b0;
    cfg_sel     = '0;
    cfg_planes  = '0;
    cfg_msb_neg = 1'b0;
    in_valid    = 1'b0;
    in_vec      = '0;
    out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_acc_en", acc_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_in_ready", in_ready, 0);
    reset_n = 1'b1;
    tick();

    // in_valid outside RUN is ignored
    set_vec(5, 5, 5, 5);
    in_valid = 1'b1;
    tick();
    chk("idle_in_ignored", acc_en, 0);
    chk("idle_busy", busy, 0);
    in_valid = 1'b0;

    // 1: single plane, {1,2,3,4}
    e0 = en_cnt;
    start_job(3, 1, 1'b0);
    chk("t1_acc_sel", acc_sel, 3);
    chk("t1_in_ready", in_ready, 1);
    set_vec(1, 2, 3, 4);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t1_acc_en", acc_en, 1);
    chk("t1_ov_at_T", out_valid, 0);
    chk("t1_in_ready_drain", in_ready, 0);
    tick();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_data", out_data, 10);
    chk("t1_acc_en_off", acc_en, 0);
    chk("t1_en_cnt", en_cnt - e0, 1);
    release_out();
    chk("t1_ov_fall", out_valid, 0);
    chk("t1_idle", busy, 0);

    // 2: planes 1,0,1 back to back -> 5
    e0 = en_cnt;
    start_job(1, 3, 1'b0);
    play(3, '{1, 0, 1, 0, 0, 0, 0, 0}, 0);
    tick();
    chk("t2_out_valid", out_valid, 1);
    chk("t2_out_data", out_data, 5);
    chk("t2_en_cnt", en_cnt - e0, 3);
    release_out();

    // 3: msb negative weight
    start_job(2, 4, 1'b1);
    play(4, '{1, 1, 1, 1, 0, 0, 0, 0}, 0);
    tick();
    chk("t3a_out_data", out_data, -1);
    release_out();
    start_job(2, 4, 1'b1);
    play(4, '{0, 0, 0, -1, 0, 0, 0, 0}, 0);
    tick();
    chk("t3b_out_data", out_data, -1);
    release_out();

    // 4: bubbles and output backpressure
    e0 = en_cnt;
    start_job(4, 3, 1'b0);
    play(3, '{1, 0, 1, 0, 0, 0, 0, 0}, 2);
    tick();
    chk("t4_en_cnt", en_cnt - e0, 3);
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_data", out_data, 5);
      tick();
    end

    // 5: back-to-back cfg during output handshake
    out_ready   = 1'b1;
    cfg_sel     = 3'd5;
    cfg_planes  = PW'(2);
    cfg_msb_neg = 1'b0;
    cfg_valid   = 1'b1;
    #1;
    chk("t5_cfg_ready", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
    out_ready = 1'b0;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_busy", busy, 1);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_acc_sel", acc_sel, 5);
    play(2, '{3, -2, 0, 0, 0, 0, 0, 0}, 0);
    tick();
    chk("t5_out_data", out_data, 4);
    release_out();

    // 6: zero planes
    e0 = en_cnt;
    start_job(0, 0, 1'b0);
    chk("t6_out_valid", out_valid, 1);
    chk("t6_out_data", out_data, 0);
    chk("t6_in_ready", in_ready, 0);
    release_out();
    chk("t6_idle", busy, 0);
    chk("t6_en_cnt", en_cnt - e0, 0);

    // planes above MAX_PLANES clamp to 8
    start_job(6, 15, 1'b0);
    play(8, '{1, 1, 1, 1, 1, 1, 1, 1}, 0);
    tick();
    chk("clamp_out_valid", out_valid, 1);
    chk("clamp_out_data", out_data, 255);
    release_out();

    // reset in the middle of a job
    start_job(7, 3, 1'b0);
    set_vec(1, 1, 1, 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rr_acc_en_pre", acc_en, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("rr_acc_en", acc_en, 0);
    chk("rr_acc_sel", acc_sel, 0);
    chk("rr_acc_vec", (acc_vec === '0), 1);
    chk("rr_busy", busy, 0);
    chk("rr_cfg_ready", cfg_ready, 1);
    chk("rr_out_valid", out_valid, 0);
    chk("rr_in_ready", in_ready, 0);
    chk("rr_out_data", out_data, 0);
    reset_n = 1'b1;
    tick();
    start_job(1, 1, 1'b0);
    play(1, '{7, 0, 0, 0, 0, 0, 0, 0}, 0);
    tick();
    chk("rr_next_job", out_data, 7);
    release_out();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
